// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Optional two's-complement input, sticky overflow and a start/busy/done handshake.
module bcd_convert_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sgn,
    input  logic [WIDTH-1:0]      binIN,
    output logic [4*DIGITS-1:0]   bcdOT,
    output logic                  neg,
    output logic                  ovf,
    output logic                  busy,
    output logic                  done
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mag;
    logic [AW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_sign;
    logic             r_ovfInt;

    logic [AW-1:0]    w_accAdj;
    logic [AW-1:0]    w_accNext;
    logic [WIDTH-1:0] w_magNext;
    logic             w_ovfNext;
    logic             w_startSign;
    logic [WIDTH-1:0] w_startMag;

    // Add-3 correction on every digit that is 5 or more, ahead of the shift.
    always_comb begin
        logic [3:0] digit;
        w_accAdj = '0;
        digit    = '0;
        for (int d = 0; d < DIGITS; d++) begin
            digit = r_acc[4*d +: 4];
            w_accAdj[4*d +: 4] = (digit >= 4'd5) ? (digit + 4'd3) : digit;
        end
    end

    assign w_accNext   = {w_accAdj[AW-2:0], r_mag[WIDTH-1]};
    assign w_magNext   = {r_mag[WIDTH-2:0], 1'b0};
    assign w_ovfNext   = r_ovfInt | w_accAdj[AW-1];

    // The most-negative operand negates to 2^(WIDTH-1), which still fits unsigned.
    assign w_startSign = sgn & binIN[WIDTH-1];
    assign w_startMag  = w_startSign ? ((~binIN) + ONE) : binIN;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mag    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_ovfInt <= 1'b0;
            bcdOT    <= '0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_mag    <= w_startMag;
                        r_sign   <= w_startSign;
                        r_acc    <= '0;
                        r_ovfInt <= 1'b0;
                        r_cnt    <= CNT_INIT;
                        busy     <= 1'b1;
                        r_state  <= CONVERT;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                CONVERT: begin
                    r_acc    <= w_accNext;
                    r_mag    <= w_magNext;
                    r_ovfInt <= w_ovfNext;
                    r_cnt    <= r_cnt - CNT_LAST;
                    if (r_cnt == CNT_LAST) begin
                        bcdOT   <= w_accNext;
                        neg     <= r_sign;
                        ovf     <= w_ovfNext;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq: directed cases, sweep and random operands
// compared against a decimal-arithmetic reference model.
module tb_bcd_convert_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8, sgn8;
    logic [7:0]  bin8;
    logic [11:0] bcd0;
    logic        neg0, ovf0, busy0, done0;
    logic [7:0]  bcd1;
    logic        neg1, ovf1, busy1, done1;

    logic        start16, sgn16;
    logic [15:0] bin16;
    logic [19:0] bcd2;
    logic        neg2, ovf2, busy2, done2;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] expBcd0 = '0;

    always #5 clk = ~clk;

    bcd_convert_seq #(.WIDTH(8), .DIGITS(3)) u0 (
        .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .binIN(bin8),
        .bcdOT(bcd0), .neg(neg0), .ovf(ovf0), .busy(busy0), .done(done0)
    );

    bcd_convert_seq #(.WIDTH(8), .DIGITS(2)) u1 (
        .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .binIN(bin8),
        .bcdOT(bcd1), .neg(neg1), .ovf(ovf1), .busy(busy1), .done(done1)
    );

    bcd_convert_seq #(.WIDTH(16), .DIGITS(5)) u2 (
        .clk(clk), .rst(rst), .start(start16), .sgn(sgn16), .binIN(bin16),
        .bcdOT(bcd2), .neg(neg2), .ovf(ovf2), .busy(busy2), .done(done2)
    );

    // Decimal reference: low 'digits' decimal digits of v, one nibble each.
    function automatic logic [19:0] toBcd(input int unsigned v, input int digits);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int unsigned pow10(input int digits);
        int unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at the falling edge just after the start edge; returns cycles until done.
    task automatic waitDone8(output int cyc);
        cyc = 0;
        while (!done0 && cyc < 40) begin
            checkOutput("busy8", 32'(busy0), 32'd1);
            checkOutput("hold8", 32'(bcd0), 32'(expBcd0));
            @(negedge clk);
            cyc++;
        end
        checkOutput("busyAtDone8", 32'(busy0), 32'd0);
    endtask

    task automatic checkResult8(input logic s, input logic [7:0] b);
        logic        isNeg;
        int unsigned mag;
        logic [19:0] e3;
        logic [19:0] e2;
        isNeg = s & b[7];
        mag   = isNeg ? (256 - int'(b)) : int'(b);
        e3    = toBcd(mag, 3);
        e2    = toBcd(mag, 2);
        checkOutput("bcd3", 32'(bcd0), 32'(e3[11:0]));
        checkOutput("neg3", 32'(neg0), 32'(isNeg));
        checkOutput("ovf3", 32'(ovf0), 32'(mag >= pow10(3)));
        checkOutput("done2", 32'(done1), 32'd1);
        checkOutput("bcd2", 32'(bcd1), 32'(e2[7:0]));
        checkOutput("neg2", 32'(neg1), 32'(isNeg));
        checkOutput("ovf2", 32'(ovf1), 32'(mag >= pow10(2)));
        expBcd0 = e3[11:0];
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] b);
        int cyc;
        @(negedge clk);
        start8 = 1'b1;
        sgn8   = s;
        bin8   = b;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        sgn8   = 1'($urandom_range(0, 1));
        bin8   = 8'($urandom);
        waitDone8(cyc);
        checkOutput("lat8", 32'(cyc), 32'd8);
        checkResult8(s, b);
        @(negedge clk);
        checkOutput("donePulse8", 32'(done0), 32'd0);
    endtask

    task automatic applyStimulus16(input logic s, input logic [15:0] b);
        int          cyc;
        logic        isNeg;
        int unsigned mag;
        logic [19:0] e5;
        @(negedge clk);
        start16 = 1'b1;
        sgn16   = s;
        bin16   = b;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        bin16   = 16'($urandom);
        cyc = 0;
        while (!done2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        isNeg = s & b[15];
        mag   = isNeg ? (65536 - int'(b)) : int'(b);
        e5    = toBcd(mag, 5);
        checkOutput("lat16", 32'(cyc), 32'd16);
        checkOutput("bcd5", 32'(bcd2), 32'(e5));
        checkOutput("neg5", 32'(neg2), 32'(isNeg));
        checkOutput("ovf5", 32'(ovf2), 32'd0);
    endtask

    initial begin
        int   cyc;
        logic sawDone;

        rst = 1'b1; start8 = 1'b0; sgn8 = 1'b0; bin8 = '0;
        start16 = 1'b0; sgn16 = 1'b0; bin16 = '0;
        repeat (3) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        checkOutput("rstBcd", 32'(bcd0), 32'd0);
        checkOutput("rstNeg", 32'(neg0), 32'd0);
        checkOutput("rstOvf", 32'(ovf0), 32'd0);
        checkOutput("rstBusy", 32'(busy0), 32'd0);
        checkOutput("rstDone", 32'(done0), 32'd0);
        start8 = 1'b0;
        rst    = 1'b0;

        $display("[TB] directed cases");
        applyStimulus(1'b0, 8'd255);
        applyStimulus(1'b1, 8'h80);
        applyStimulus(1'b1, 8'hFF);
        applyStimulus(1'b0, 8'd100);
        applyStimulus(1'b0, 8'd99);
        applyStimulus(1'b1, 8'h7F);

        $display("[TB] start held, ignored during convert, back-to-back");
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b0; bin8 = 8'd42;
        @(posedge clk);
        @(negedge clk);
        bin8 = 8'd7;
        waitDone8(cyc);
        checkOutput("latHeld", 32'(cyc), 32'd8);
        checkResult8(1'b0, 8'd42);
        bin8 = 8'd13;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        waitDone8(cyc);
        checkOutput("latB2B", 32'(cyc), 32'd8);
        checkResult8(1'b0, 8'd13);

        $display("[TB] reset mid-conversion");
        applyStimulus(1'b1, 8'hF0);
        @(negedge clk);
        start8 = 1'b1; sgn8 = 1'b0; bin8 = 8'd200;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortBcd", 32'(bcd0), 32'd0);
        checkOutput("abortNeg", 32'(neg0), 32'd0);
        checkOutput("abortBusy", 32'(busy0), 32'd0);
        checkOutput("abortBcd2", 32'(bcd1), 32'd0);
        sawDone = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done0) sawDone = 1'b1;
        end
        checkOutput("abortNoDone", 32'(sawDone), 32'd0);
        expBcd0 = '0;
        applyStimulus(1'b0, 8'd0);

        $display("[TB] wide instance");
        applyStimulus16(1'b0, 16'd65535);
        applyStimulus16(1'b1, 16'h8000);
        for (int i = 0; i < 20; i++)
            applyStimulus16(1'($urandom_range(0, 1)), 16'($urandom));

        $display("[TB] unsigned sweep 0..255");
        for (int v = 0; v < 256; v++)
            applyStimulus(1'b0, 8'(v));

        $display("[TB] random signed/unsigned operands");
        for (int i = 0; i < 150; i++)
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_convert_seq.md
Name: bcd_convert_seq

Overview:
- Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Processes one input bit per clock. Every BCD digit is corrected by add-3 when it is at least 5, before each shift.
- Generalises the fixed 4-bit add-3 cell to any input width and digit count. Adds an optional signed mode, overflow detection and a start/done handshake.
- Sits between arithmetic datapaths and 7-segment display drivers.

Parameters:
WIDTH, 8, binary input width in bits (>=2)
DIGITS, 3, number of BCD output digits (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request conversion; sampled on the rising edge
sgn  input  1  1 = treat binIN as two's complement; sampled with start
binIN  input  WIDTH  binary operand; sampled with start
bcdOT  output  4*DIGITS  BCD result, digit 0 in bits [3:0]; holds the last result
neg  output  1  result sign; 1 only if sgn=1 and the operand was negative
ovf  output  1  magnitude exceeded 10^DIGITS-1; bcdOT then holds the low digits only
busy  output  1  high while in CONVERT
done  output  1  one-cycle pulse when bcdOT/neg/ovf update

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset: state=IDLE; bcdOT=0, neg=0, ovf=0, busy=0, done=0. The internal shift register, accumulator and counter are cleared.
  - rst overrides start in the same cycle.
  - rst asserted mid-conversion aborts it. No done pulse is produced, and outputs return to 0.
- States: IDLE, CONVERT, DONE.
- IDLE, or DONE, with start=1:
  - Latch the magnitude: binIN if sgn=0 or binIN[WIDTH-1]=0; otherwise the two's-complement negation, taken as a WIDTH-bit unsigned value. Most-negative input gives 2^(WIDTH-1).
  - Latch sign_int = sgn & binIN[WIDTH-1].
  - Clear the accumulator (4*DIGITS bits) and the internal overflow flag. Set counter=WIDTH. Go to CONVERT.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- CONVERT, per cycle:
  - (a) every accumulator digit >=5 gets +3, mod 16 per digit;
  - (b) shift {accumulator, magnitude} left by 1. The bit leaving the accumulator MSB sets the internal overflow flag if it is 1 (sticky);
  - (c) decrement the counter.
  - When the counter goes 1->0, move to DONE. On that same edge, register bcdOT=accumulator after (b), neg=sign_int and ovf=overflow flag.
- start is ignored while in CONVERT. The latched operand is unaffected by input changes after the start cycle.
- DONE: done=1 for exactly this cycle.
- Latency: start sampled at edge 0, done high during the cycle after edge WIDTH. Throughput is one result per WIDTH+1 cycles; start held high gives back-to-back conversions.
- busy=1 exactly during the WIDTH CONVERT cycles.
- bcdOT/neg/ovf change only on entry to DONE or on rst. They are stable otherwise, including throughout a subsequent conversion.
- Zero input: bcdOT=0, neg=0, ovf=0. Negative zero cannot occur.
- Digits never hold values above 9 in bcdOT unless ovf=1. Even with ovf=1 the digits remain 0-9.

Test Plan:
- WIDTH=8, DIGITS=3, sgn=0, binIN=8'd255, start pulse at edge 0 -> busy high for 8 cycles; done high in cycle 9 only; bcdOT=12'h255, neg=0, ovf=0.
- WIDTH=8, sgn=1, binIN=8'h80 (-128) -> bcdOT=12'h128, neg=1, ovf=0. Then binIN=8'hFF, sgn=1 -> bcdOT=12'h001, neg=1.
- WIDTH=8, DIGITS=2, sgn=0, binIN=8'd100 -> ovf=1, bcdOT=8'h00. binIN=8'd99 -> ovf=0, bcdOT=8'h99.
- Start pulse with binIN=8'd42, then start=1 with binIN=8'd7 during CONVERT -> ignored; result 12'h042. Start held high through done -> second conversion begins in the DONE cycle, done again 9 cycles later.
- rst asserted on cycle 4 of a conversion of 8'd200 -> all outputs 0 next cycle, no done pulse. A fresh start of 8'd0 -> bcdOT=0, done at edge 9.
- WIDTH=16, DIGITS=5, binIN=16'd65535 -> bcdOT=20'h65535, done in cycle 17. Exhaustive sweep of 0..255 at WIDTH=8 matched against a decimal model.
